// File: rtl/ppu_regs.sv
// ppu_regs: CPU-facing PPU register file ($2000-$2007, mirrored every 8 bytes).
// Holds PPUCTRL/PPUMASK, the status flags, OAMADDR, the loopy t/v/fine_x/w scroll
// state and the buffered PPUDATA path that issues single-cycle PPU bus accesses.
module ppu_regs #(
  parameter int RD_LATENCY     = 1,
  parameter int OPEN_BUS_DECAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  output logic        nmi,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  output logic [7:0]  ctrl_o,
  output logic [7:0]  mask_o,
  output logic [14:0] v_o,
  output logic [14:0] t_o,
  output logic [2:0]  fine_x_o,
  input  logic        copy_h,
  input  logic        copy_v,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_we,
  input  logic [7:0]  oam_data_i,
  output logic        ppu_req,
  output logic        ppu_rw,
  output logic [13:0] ppu_addr_o,
  output logic [7:0]  ppu_data_o,
  input  logic [7:0]  ppu_data_i
);

  // Last count value before the open-bus latch decays (unused when decay is off).
  localparam logic [15:0] DECAY_LAST = 16'(OPEN_BUS_DECAY - 1);

  logic [7:0]  ctrl_r, mask_r;
  logic        vbl_r, s0_r, ovf_r;
  logic [14:0] t_r, v_r;
  logic [2:0]  fine_x_r;
  logic        w_r;
  logic [7:0]  oam_addr_r, oam_data_r;
  logic        oam_we_r, oam_inc_r;
  logic        ppu_req_r, ppu_rw_r;
  logic [13:0] ppu_addr_r;
  logic [7:0]  ppu_data_r;
  logic [7:0]  rd_buf_r, latch_r;
  logic [15:0] decay_cnt_r;
  logic [RD_LATENCY:0] rd_pipe_r;

  logic        wr_s, rd_s;
  logic        data_wr_s, data_rd_s;
  logic [7:0]  status_s, rd_mux_s;
  logic [14:0] v_inc_s, v_copy_s;
  logic [14:0] t_next_s, v_next_s;
  logic [2:0]  fine_x_next_s;
  logic        w_next_s;

  assign wr_s      = cpu_cs & ~cpu_rw;
  assign rd_s      = cpu_cs & cpu_rw;
  assign data_wr_s = wr_s & (cpu_addr == 3'd7);
  assign data_rd_s = rd_s & (cpu_addr == 3'd7);

  // v after a PPUDATA access, and v after any renderer copies from t.
  assign v_inc_s  = v_r + (ctrl_r[2] ? 15'd32 : 15'd1);
  assign v_copy_s = {copy_v ? t_r[14:11] : v_r[14:11],
                     copy_h ? t_r[10]    : v_r[10],
                     copy_v ? t_r[9:5]   : v_r[9:5],
                     copy_h ? t_r[4:0]   : v_r[4:0]};

  assign ctrl_o     = ctrl_r;
  assign mask_o     = mask_r;
  assign v_o        = v_r;
  assign t_o        = t_r;
  assign fine_x_o   = fine_x_r;
  assign oam_addr_o = oam_addr_r;
  assign oam_data_o = oam_data_r;
  assign oam_we     = oam_we_r;
  assign ppu_req    = ppu_req_r;
  assign ppu_rw     = ppu_rw_r;
  assign ppu_addr_o = ppu_addr_r;
  assign ppu_data_o = ppu_data_r;
  assign nmi        = ctrl_r[7] & vbl_r;

  // CPU read mux; a vblank_set landing on a status read is hidden from that read.
  always_comb begin
    status_s = {vbl_r & ~vblank_set, s0_r, ovf_r, latch_r[4:0]};
    case (cpu_addr)
      3'd2:    rd_mux_s = status_s;
      3'd4:    rd_mux_s = oam_data_i;
      3'd7:    rd_mux_s = rd_buf_r;
      default: rd_mux_s = latch_r;
    endcase
    if (rd_s) begin
      cpu_data_o = rd_mux_s;
    end else begin
      cpu_data_o = 8'h00;
    end
  end

  // Next scroll state; CPU updates of v override renderer copies in the same clock.
  always_comb begin
    t_next_s      = t_r;
    fine_x_next_s = fine_x_r;
    w_next_s      = w_r;
    v_next_s      = v_copy_s;
    if (wr_s) begin
      case (cpu_addr)
        3'd0: t_next_s[11:10] = cpu_data_i[1:0];
        3'd5: begin
          if (!w_r) begin
            t_next_s[4:0] = cpu_data_i[7:3];
            fine_x_next_s = cpu_data_i[2:0];
            w_next_s      = 1'b1;
          end else begin
            t_next_s[14:12] = cpu_data_i[2:0];
            t_next_s[9:5]   = cpu_data_i[7:3];
            w_next_s        = 1'b0;
          end
        end
        3'd6: begin
          if (!w_r) begin
            t_next_s[13:8] = cpu_data_i[5:0];
            t_next_s[14]   = 1'b0;
            w_next_s       = 1'b1;
          end else begin
            t_next_s[7:0] = cpu_data_i;
            v_next_s      = {t_r[14:8], cpu_data_i};
            w_next_s      = 1'b0;
          end
        end
        3'd7:    v_next_s = v_inc_s;
        default: t_next_s = t_r;
      endcase
    end else if (rd_s) begin
      case (cpu_addr)
        3'd2:    w_next_s = 1'b0;
        3'd7:    v_next_s = v_inc_s;
        default: w_next_s = w_r;
      endcase
    end else begin
      v_next_s = v_copy_s;
    end
  end

  // Control, mask and scroll registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r   <= 8'h00;
      mask_r   <= 8'h00;
      t_r      <= 15'h0000;
      v_r      <= 15'h0000;
      fine_x_r <= 3'd0;
      w_r      <= 1'b0;
    end else begin
      if (wr_s && (cpu_addr == 3'd0)) begin
        ctrl_r <= cpu_data_i;
      end
      if (wr_s && (cpu_addr == 3'd1)) begin
        mask_r <= cpu_data_i;
      end
      t_r      <= t_next_s;
      v_r      <= v_next_s;
      fine_x_r <= fine_x_next_s;
      w_r      <= w_next_s;
    end
  end

  // Status flags: clear pulse beats set; a status read clears vbl and suppresses a coincident set.
  always_ff @(posedge clk) begin
    if (rst) begin
      vbl_r <= 1'b0;
      s0_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      vbl_r <= ~vblank_clr & ~(rd_s && (cpu_addr == 3'd2)) & (vblank_set | vbl_r);
      s0_r  <= ~vblank_clr & (spr0_hit | s0_r);
      ovf_r <= ~vblank_clr & (spr_ovf | ovf_r);
    end
  end

  // OAM port: a data write strobes at the current address, which advances one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      oam_addr_r <= 8'h00;
      oam_data_r <= 8'h00;
      oam_we_r   <= 1'b0;
      oam_inc_r  <= 1'b0;
    end else begin
      oam_we_r <= wr_s && (cpu_addr == 3'd4);
      if (wr_s && (cpu_addr == 3'd3)) begin
        oam_addr_r <= cpu_data_i;
        oam_inc_r  <= 1'b0;
      end else if (wr_s && (cpu_addr == 3'd4)) begin
        oam_addr_r <= oam_inc_r ? oam_addr_r + 8'd1 : oam_addr_r;
        oam_data_r <= cpu_data_i;
        oam_inc_r  <= 1'b1;
      end else if (oam_inc_r) begin
        oam_addr_r <= oam_addr_r + 8'd1;
        oam_inc_r  <= 1'b0;
      end
    end
  end

  // PPU bus request and the read buffer fill RD_LATENCY clocks after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_req_r  <= 1'b0;
      ppu_rw_r   <= 1'b1;
      ppu_addr_r <= 14'h0000;
      ppu_data_r <= 8'h00;
      rd_buf_r   <= 8'h00;
      rd_pipe_r  <= '0;
    end else begin
      ppu_req_r <= data_wr_s | data_rd_s;
      ppu_rw_r  <= ~data_wr_s;
      if (data_wr_s || data_rd_s) begin
        ppu_addr_r <= v_r[13:0];
      end
      if (data_wr_s) begin
        ppu_data_r <= cpu_data_i;
      end
      rd_pipe_r <= {rd_pipe_r[RD_LATENCY-1:0], data_rd_s};
      if (rd_pipe_r[RD_LATENCY]) begin
        rd_buf_r <= ppu_data_i;
      end
    end
  end

  // Open-bus latch: refreshed by every access, optionally decaying to 0 when left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_r     <= 8'h00;
      decay_cnt_r <= 16'h0000;
    end else if (cpu_cs) begin
      latch_r     <= cpu_rw ? rd_mux_s : cpu_data_i;
      decay_cnt_r <= 16'h0000;
    end else if (OPEN_BUS_DECAY != 0) begin
      if (decay_cnt_r == DECAY_LAST) begin
        latch_r <= 8'h00;
      end else begin
        decay_cnt_r <= decay_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_regs.sv
// tb_ppu_regs: randomized self-checking bench for ppu_regs against a behavioural model.
module tb_ppu_regs;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cs = 1'b0, cpu_rw = 1'b1;
  logic [2:0]  cpu_addr = 3'd0;
  logic [7:0]  cpu_data_i = 8'h00;
  logic [7:0]  cpu_data_o;
  logic        nmi;
  logic        vblank_set = 1'b0, vblank_clr = 1'b0, spr0_hit = 1'b0, spr_ovf = 1'b0;
  logic [7:0]  ctrl_o, mask_o;
  logic [14:0] v_o, t_o;
  logic [2:0]  fine_x_o;
  logic        copy_h = 1'b0, copy_v = 1'b0;
  logic [7:0]  oam_addr_o, oam_data_o;
  logic        oam_we;
  logic [7:0]  oam_data_i = 8'h00;
  logic        ppu_req, ppu_rw;
  logic [13:0] ppu_addr_o;
  logic [7:0]  ppu_data_o;
  logic [7:0]  ppu_data_i = 8'h00;

  always #5 clk = ~clk;

  ppu_regs #(.RD_LATENCY(L), .OPEN_BUS_DECAY(0)) dut (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .nmi(nmi),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_hit(spr0_hit), .spr_ovf(spr_ovf),
    .ctrl_o(ctrl_o), .mask_o(mask_o), .v_o(v_o), .t_o(t_o), .fine_x_o(fine_x_o),
    .copy_h(copy_h), .copy_v(copy_v), .oam_addr_o(oam_addr_o), .oam_data_o(oam_data_o),
    .oam_we(oam_we), .oam_data_i(oam_data_i), .ppu_req(ppu_req), .ppu_rw(ppu_rw),
    .ppu_addr_o(ppu_addr_o), .ppu_data_o(ppu_data_o), .ppu_data_i(ppu_data_i)
  );

  // Behavioural model state (plain integers)
  int m_ctrl, m_mask, m_vbl, m_s0, m_ovf, m_t, m_v, m_fx, m_w, m_buf, m_latch;
  int m_oam_addr, m_oam_pend, m_we, m_oam_data;
  int m_req, m_prw = 1, m_paddr, m_pdata;
  int cyc = 0;
  logic [7:0] mem [0:16383];
  typedef struct { int due; logic [7:0] data; } rd_t;
  rd_t q[$];

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Value a CPU read must return right now (pre-edge state, current inputs)
  function automatic int read_val();
    case (cpu_addr)
      3'd2: return ((m_vbl != 0 && !vblank_set) ? 128 : 0) + 64 * m_s0 + 32 * m_ovf + (m_latch % 32);
      3'd4: return int'(oam_data_i);
      3'd7: return m_buf;
      default: return m_latch;
    endcase
  endfunction

  task automatic model_update();
    int r, d, a, t_old;
    bit wr, rd, cpu_v;
    cyc++;
    if (rst) begin
      m_ctrl = 0; m_mask = 0; m_vbl = 0; m_s0 = 0; m_ovf = 0; m_t = 0; m_v = 0; m_fx = 0;
      m_w = 0; m_buf = 0; m_latch = 0; m_oam_addr = 0; m_oam_pend = 0; m_we = 0;
      m_oam_data = 0; m_req = 0; m_prw = 1; m_paddr = 0; m_pdata = 0;
      q.delete();
      return;
    end
    r = read_val(); d = int'(cpu_data_i); a = int'(cpu_addr);
    wr = cpu_cs && !cpu_rw; rd = cpu_cs && cpu_rw;
    if (q.size() > 0 && q[0].due == cyc - 1) begin
      m_buf = int'(q[0].data);
      q.delete(0);
    end
    if (cpu_cs) m_latch = rd ? r : d;
    if (vblank_clr) begin
      m_vbl = 0; m_s0 = 0; m_ovf = 0;
    end else begin
      if (rd && a == 2) m_vbl = 0;
      else if (vblank_set) m_vbl = 1;
      if (spr0_hit) m_s0 = 1;
      if (spr_ovf) m_ovf = 1;
    end
    m_we = (wr && a == 4) ? 1 : 0;
    if (wr && a == 3) begin
      m_oam_addr = d; m_oam_pend = 0;
    end else if (wr && a == 4) begin
      if (m_oam_pend != 0) m_oam_addr = (m_oam_addr + 1) % 256;
      m_oam_data = d; m_oam_pend = 1;
    end else if (m_oam_pend != 0) begin
      m_oam_addr = (m_oam_addr + 1) % 256; m_oam_pend = 0;
    end
    m_req = (cpu_cs && a == 7) ? 1 : 0;
    m_prw = (wr && a == 7) ? 0 : 1;
    if (m_req != 0) m_paddr = m_v % 16384;
    if (wr && a == 7) begin
      m_pdata = d; mem[m_v % 16384] = 8'(d);
    end
    if (rd && a == 7) q.push_back('{due: cyc + L, data: mem[m_v % 16384]});
    t_old = m_t; cpu_v = 1'b0;
    if (wr) begin
      case (a)
        0: begin m_ctrl = d; m_t = (m_t & ~32'h0C00) | ((d % 4) << 10); end
        1: m_mask = d;
        5: if (m_w == 0) begin
             m_t = (m_t & ~32'h001F) | (d / 8); m_fx = d % 8; m_w = 1;
           end else begin
             m_t = (m_t & ~32'h73E0) | ((d % 8) << 12) | ((d / 8) << 5); m_w = 0;
           end
        6: if (m_w == 0) begin
             m_t = (m_t & 32'h00FF) | ((d % 64) << 8); m_w = 1;
           end else begin
             m_t = (m_t & 32'h7F00) | d; m_v = m_t; cpu_v = 1'b1; m_w = 0;
           end
        7: begin m_v = (m_v + (((m_ctrl & 4) != 0) ? 32 : 1)) % 32768; cpu_v = 1'b1; end
        default: ;
      endcase
    end
    if (rd && a == 2) m_w = 0;
    if (rd && a == 7) begin
      m_v = (m_v + (((m_ctrl & 4) != 0) ? 32 : 1)) % 32768; cpu_v = 1'b1;
    end
    if (!cpu_v) begin
      if (copy_h) m_v = (m_v & ~32'h041F) | (t_old & 32'h041F);
      if (copy_v) m_v = (m_v & ~32'h7BE0) | (t_old & 32'h7BE0);
    end
  endtask

  // One clock: model follows the edge, pulses drop, bus/OAM read data re-driven
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    vblank_set = 1'b0; vblank_clr = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
    copy_h = 1'b0; copy_v = 1'b0;
    oam_data_i = 8'($urandom);
    ppu_data_i = 8'($urandom);
    foreach (q[i]) if (q[i].due == cyc) ppu_data_i = q[i].data;
  endtask

  task automatic strobe(input bit rw, input int a, input int d, output int rv);
    cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = a[2:0]; cpu_data_i = d[7:0];
    #2;
    rv = int'(cpu_data_o);
    tick();
    cpu_cs = 1'b0;
  endtask

  task automatic access(input bit rw, input int a, input int d, output int rv);
    strobe(rw, a, d, rv);
    repeat (3) tick();
  endtask

  task automatic rand_pulses();
    vblank_set = ($urandom_range(0, 11) == 0);
    vblank_clr = ($urandom_range(0, 15) == 0);
    spr0_hit   = ($urandom_range(0, 11) == 0);
    spr_ovf    = ($urandom_range(0, 11) == 0);
    copy_h     = ($urandom_range(0, 7) == 0);
    copy_v     = ($urandom_range(0, 7) == 0);
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", int'(ctrl_o), m_ctrl);
      check("mask", int'(mask_o), m_mask);
      check("v", int'(v_o), m_v);
      check("t", int'(t_o), m_t);
      check("fine_x", int'(fine_x_o), m_fx);
      check("oam_addr", int'(oam_addr_o), m_oam_addr);
      check("oam_we", int'(oam_we), m_we);
      if (m_we != 0) check("oam_data", int'(oam_data_o), m_oam_data);
      check("nmi", int'(nmi), (((m_ctrl & 128) != 0) && (m_vbl != 0)) ? 1 : 0);
      check("ppu_req", int'(ppu_req), m_req);
      check("ppu_rw", int'(ppu_rw), m_prw);
      if (m_req != 0) check("ppu_addr", int'(ppu_addr_o), m_paddr);
      if (m_req != 0 && m_prw == 0) check("ppu_data", int'(ppu_data_o), m_pdata);
      if (cpu_cs && cpu_rw) check("cpu_data", int'(cpu_data_o), read_val());
    end
  end

  initial begin
    int rv;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[16'h3F00] = 8'h11;
    mem[16'h3F20] = 8'h22;

    // Reset, then idle
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_ctrl", int'(ctrl_o), 0);
    check("rst_v", int'(v_o), 0);
    check("rst_t", int'(t_o), 0);
    check("rst_oam_addr", int'(oam_addr_o), 0);
    check("rst_ppu_req", int'(ppu_req), 0);
    check("rst_ppu_rw", int'(ppu_rw), 1);
    check("rst_nmi", int'(nmi), 0);

    // PPUADDR then PPUDATA write
    access(1'b0, 6, 'h21, rv);
    access(1'b0, 6, 'h08, rv);
    strobe(1'b0, 7, 'h5A, rv);
    check("wr_req", int'(ppu_req), 1);
    check("wr_rw", int'(ppu_rw), 0);
    check("wr_addr", int'(ppu_addr_o), 'h2108);
    check("wr_data", int'(ppu_data_o), 'h5A);
    check("wr_v_inc", int'(v_o), 'h2109);
    repeat (3) tick();

    // Buffered reads with +32 increment
    access(1'b0, 0, 'h04, rv);
    access(1'b0, 6, 'h3F, rv);
    access(1'b0, 6, 'h00, rv);
    access(1'b1, 7, 0, rv);
    check("rd1_old_buf", rv, 0);
    access(1'b1, 7, 0, rv);
    check("rd2_buf", rv, 'h11);
    check("rd_v", int'(v_o), 'h3F40);

    // VBlank, NMI and read suppression
    access(1'b0, 0, 'h80, rv);
    vblank_set = 1'b1;
    tick();
    check("nmi_set", int'(nmi), 1);
    strobe(1'b1, 2, 0, rv);
    check("status_rd", rv, 'h80);
    check("nmi_after_rd", int'(nmi), 0);
    repeat (3) tick();
    vblank_set = 1'b1;
    access(1'b1, 2, 0, rv);
    check("status_supp", rv, 'h00);
    check("nmi_supp", int'(nmi), 0);
    access(1'b0, 0, 'h00, rv);
    vblank_set = 1'b1;
    tick();
    check("nmi_masked", int'(nmi), 0);
    strobe(1'b0, 0, 'h80, rv);
    check("nmi_late_enable", int'(nmi), 1);
    repeat (3) tick();
    vblank_clr = 1'b1;
    tick();
    check("nmi_vblank_clr", int'(nmi), 0);

    // Scroll writes and renderer copies
    access(1'b0, 5, 'h7D, rv);
    access(1'b0, 5, 'h5E, rv);
    check("scroll_t", int'(t_o), 'h616F);
    check("scroll_fx", int'(fine_x_o), 5);
    copy_h = 1'b1;
    tick();
    copy_v = 1'b1;
    tick();
    check("copy_v_eq_t", int'(v_o), 'h616F);

    // OAM writes with wrap
    access(1'b0, 3, 'hFF, rv);
    strobe(1'b0, 4, 'hAA, rv);
    check("oam_we1", int'(oam_we), 1);
    check("oam_addr1", int'(oam_addr_o), 'hFF);
    check("oam_data1", int'(oam_data_o), 'hAA);
    repeat (3) tick();
    strobe(1'b0, 4, 'hBB, rv);
    check("oam_we2", int'(oam_we), 1);
    check("oam_addr2", int'(oam_addr_o), 'h00);
    check("oam_data2", int'(oam_data_o), 'hBB);
    repeat (3) tick();
    check("oam_addr_end", int'(oam_addr_o), 'h01);

    // Randomized traffic with random timing pulses
    for (int i = 0; i < 600; i++) begin
      rand_pulses();
      strobe(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), rv);
      repeat (3) begin
        rand_pulses();
        tick();
      end
    end

    // Reset in the middle of a PPUDATA read
    strobe(1'b1, 7, 0, rv);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_req", int'(ppu_req), 0);
    repeat (2) tick();
    access(1'b1, 7, 0, rv);
    check("rst_mid_buf", rv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
